cv32e40p_fpu_wb_sched: RTL and testbench

Issue/writeback scheduler between the ID stage and the FPU datapath. It tracks in-flight FPU operations of three classes: pipelined ADDMUL, pipelined OTHERS (fixed latencies), and iterative DIVSQRT (variable latency). It grants issue only when there is no RAW/WAW hazard and no collision on the shared register-file write port. It also arbitrates that port against other (ALU/LSU) writers.

---
 rtl/cv32e40p_fpu_sched_pkg.sv | 23 ++
 rtl/cv32e40p_fpu_wb_slots.sv | 53 +++++
 rtl/cv32e40p_fpu_wb_sched.sv | 105 ++++++++++
 tb/tb_cv32e40p_fpu_wb_sched.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_fpu_sched_pkg.sv
// cv32e40p_fpu_sched_pkg: shared types and latency helper for the FPU writeback scheduler
package cv32e40p_fpu_sched_pkg;

  typedef enum logic [1:0] {
    ADDMUL  = 2'd0,
    OTHERS  = 2'd1,
    DIVSQRT = 2'd2
  } fpu_class_e;

  localparam int SLOT_RD_W = 6;

  typedef struct packed {
    logic                 valid;
    logic [SLOT_RD_W-1:0] rd;
  } wb_slot_t;

  // The reserved class encoding falls through to the OTHERS latency.
  function automatic logic [1:0] lat_of(input logic [1:0] cls, input int addmul_lat,
                                        input int others_lat);
    return cls == ADDMUL ? 2'(addmul_lat) : 2'(others_lat);
  endfunction

endpackage

// File: rtl/cv32e40p_fpu_wb_slots.sv
// cv32e40p_fpu_wb_slots: writeback slot shift array with parallel destination compare
module cv32e40p_fpu_wb_slots
  import cv32e40p_fpu_sched_pkg::*;
#(
  parameter int D  = 2,
  parameter int AW = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ins_en,
  input  logic [1:0]           ins_lat,
  input  logic [AW-1:0]        ins_rd,
  input  logic [3:0][AW-1:0]   cmp_addr,
  output logic [D-1:0]         slot_v,
  output logic [D-1:0][AW-1:0] slot_rd,
  output logic [3:0]           match
);

  logic [D-1:0]         nxt_v;
  logic [D-1:0][AW-1:0] nxt_rd;

  // Slot k retires k cycles from now; an op of latency L lands in slot L-1 after the shift.
  always_comb begin
    nxt_v  = slot_v >> 1;
    nxt_rd = slot_rd >> AW;
    for (int k = 0; k < D; k++) begin
      if (ins_en && int'(ins_lat) == k + 1) begin
        nxt_v[k]  = 1'b1;
        nxt_rd[k] = ins_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_v  <= '0;
      slot_rd <= '0;
    end else begin
      slot_v  <= nxt_v;
      slot_rd <= nxt_rd;
    end
  end

  always_comb begin
    match = '0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < D; k++) begin
        if (slot_v[k] && cmp_addr[i] != '0 && slot_rd[k] == cmp_addr[i]) match[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cv32e40p_fpu_wb_sched.sv
// cv32e40p_fpu_wb_sched: FPU issue gating on hazards and shared register-file write port arbitration
module cv32e40p_fpu_wb_sched
  import cv32e40p_fpu_sched_pkg::*;
#(
  parameter int ADDMUL_LAT = 1,
  parameter int OTHERS_LAT = 1,
  parameter int ZFINX      = 0,
  parameter int REG_ADDR_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [1:0]            issue_class_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  input  logic [REG_ADDR_W-1:0] issue_rs1_i,
  input  logic [REG_ADDR_W-1:0] issue_rs2_i,
  input  logic [REG_ADDR_W-1:0] issue_rs3_i,
  input  logic [2:0]            issue_rs_used_i,
  input  logic                  div_done_i,
  output logic                  div_ack_o,
  output logic                  wb_valid_o,
  output logic [REG_ADDR_W-1:0] wb_rd_o,
  input  logic                  ext_wb_req_i,
  output logic                  ext_wb_gnt_o,
  output logic                  busy_o
);

  localparam int D = (ADDMUL_LAT > OTHERS_LAT ? ADDMUL_LAT : OTHERS_LAT) + 1;
  localparam logic [REG_ADDR_W-1:0] FP_BIT = REG_ADDR_W'(32);

  logic [D-1:0]                 slot_v;
  logic [D-1:0][REG_ADDR_W-1:0] slot_rd;
  logic [3:0][REG_ADDR_W-1:0]   cmp;
  logic [3:0]                   slot_match;
  logic [3:0]                   div_match;
  logic [3:0]                   used;
  logic [1:0]                   lat;
  logic                         div_pending;
  logic [REG_ADDR_W-1:0]        div_rd;
  logic                         is_div;
  logic                         hazard;
  logic                         collision;
  logic                         div_stall;
  logic                         fire;
  logic                         fire0;

  // Under Zfinx every operand lives in the integer file, so the file-select bit is dropped.
  function automatic logic [REG_ADDR_W-1:0] norm(input logic [REG_ADDR_W-1:0] a);
    return ZFINX != 0 ? a & ~FP_BIT : a;
  endfunction

  assign is_div = issue_class_i == DIVSQRT;
  assign lat    = lat_of(issue_class_i, ADDMUL_LAT, OTHERS_LAT);
  assign cmp    = {norm(issue_rd_i), norm(issue_rs3_i), norm(issue_rs2_i), norm(issue_rs1_i)};
  assign used   = {1'b1, issue_rs_used_i};

  cv32e40p_fpu_wb_slots #(
    .D (D),
    .AW(REG_ADDR_W)
  ) u_slots (
    .clk     (clk),
    .rst_n   (rst_n),
    .ins_en  (fire && !is_div && lat != 2'd0),
    .ins_lat (lat),
    .ins_rd  (cmp[3]),
    .cmp_addr(cmp),
    .slot_v  (slot_v),
    .slot_rd (slot_rd),
    .match   (slot_match)
  );

  for (genvar i = 0; i < 4; i++) begin : g_div_match
    assign div_match[i] = div_pending && cmp[i] != '0 && cmp[i] == div_rd;
  end

  assign hazard    = |(used & (slot_match | div_match));
  assign collision = !is_div && (lat == 2'd0 ? slot_v[0] | div_done_i
                                              : |(slot_v & (D'(1) << lat)));
  assign div_ack_o = div_done_i & div_pending & ~slot_v[0];
  // A retiring divide frees the unit in time for a back-to-back divide issue.
  assign div_stall = is_div & div_pending & ~div_ack_o;

  assign issue_ready_o = ~(hazard | collision | div_stall);
  assign fire          = issue_valid_i & issue_ready_o;
  assign fire0         = fire & ~is_div & (lat == 2'd0);

  assign wb_valid_o   = slot_v[0] | div_ack_o | fire0;
  assign wb_rd_o      = slot_v[0] ? slot_rd[0] : div_ack_o ? div_rd : fire0 ? cmp[3] : '0;
  assign ext_wb_gnt_o = ext_wb_req_i & ~wb_valid_o;
  assign busy_o       = |slot_v | div_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_pending <= 1'b0;
      div_rd      <= '0;
    end else if (fire && is_div) begin
      div_pending <= 1'b1;
      div_rd      <= cmp[3];
    end else if (div_ack_o) begin
      div_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cv32e40p_fpu_wb_sched.sv
// tb_cv32e40p_fpu_wb_sched: directed table, reset sequence and randomized model check of two configurations
module tb_cv32e40p_fpu_wb_sched;

  typedef struct {
    logic       ready, wbv, ack, gnt, busy;
    logic [5:0] wbrd;
  } obs_t;

  typedef struct {
    logic       v;
    logic [1:0] cls;
    logic [5:0] rd, rs1, rs2, rs3;
    logic [2:0] used;
    logic       done, req;
    obs_t       e;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       issue_valid;
  logic [1:0] issue_class;
  logic [5:0] issue_rd, rs1, rs2, rs3;
  logic [2:0] rs_used;
  logic       div_done, ext_req;

  logic       a_ready, a_ack, a_wbv, a_gnt, a_busy;
  logic [5:0] a_wbrd;
  logic       b_ready, b_ack, b_wbv, b_gnt, b_busy;
  logic [5:0] b_wbrd;

  always #5 clk = ~clk;

  cv32e40p_fpu_wb_sched #(.ADDMUL_LAT(1), .OTHERS_LAT(2), .ZFINX(0), .REG_ADDR_W(6)) dut_a (
    .clk(clk), .rst_n(rst_n), .issue_valid_i(issue_valid), .issue_ready_o(a_ready),
    .issue_class_i(issue_class), .issue_rd_i(issue_rd), .issue_rs1_i(rs1), .issue_rs2_i(rs2),
    .issue_rs3_i(rs3), .issue_rs_used_i(rs_used), .div_done_i(div_done), .div_ack_o(a_ack),
    .wb_valid_o(a_wbv), .wb_rd_o(a_wbrd), .ext_wb_req_i(ext_req), .ext_wb_gnt_o(a_gnt),
    .busy_o(a_busy));

  cv32e40p_fpu_wb_sched #(.ADDMUL_LAT(0), .OTHERS_LAT(3), .ZFINX(1), .REG_ADDR_W(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .issue_valid_i(issue_valid), .issue_ready_o(b_ready),
    .issue_class_i(issue_class), .issue_rd_i(issue_rd), .issue_rs1_i(rs1), .issue_rs2_i(rs2),
    .issue_rs3_i(rs3), .issue_rs_used_i(rs_used), .div_done_i(div_done), .div_ack_o(b_ack),
    .wb_valid_o(b_wbv), .wb_rd_o(b_wbrd), .ext_wb_req_i(ext_req), .ext_wb_gnt_o(b_gnt),
    .busy_o(b_busy));

  function automatic obs_t act(int n);
    obs_t o;
    o.ready = n == 0 ? a_ready : b_ready;
    o.wbv   = n == 0 ? a_wbv   : b_wbv;
    o.wbrd  = n == 0 ? a_wbrd  : b_wbrd;
    o.ack   = n == 0 ? a_ack   : b_ack;
    o.gnt   = n == 0 ? a_gnt   : b_gnt;
    o.busy  = n == 0 ? a_busy  : b_busy;
    return o;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic cmp_obs(string tag, obs_t g, obs_t e);
    chk({tag, ".ready"}, 32'(g.ready), 32'(e.ready));
    chk({tag, ".wb_valid"}, 32'(g.wbv), 32'(e.wbv));
    chk({tag, ".wb_rd"}, 32'(g.wbrd), 32'(e.wbrd));
    chk({tag, ".div_ack"}, 32'(g.ack), 32'(e.ack));
    chk({tag, ".ext_gnt"}, 32'(g.gnt), 32'(e.gnt));
    chk({tag, ".busy"}, 32'(g.busy), 32'(e.busy));
  endtask

  task automatic drive(int v, int cls, int rd, int r1, int r2, int r3, int u, int dn, int rq);
    issue_valid = v != 0;
    issue_class = 2'(cls);
    issue_rd    = 6'(rd);
    rs1         = 6'(r1);
    rs2         = 6'(r2);
    rs3         = 6'(r3);
    rs_used     = 3'(u);
    div_done    = dn != 0;
    ext_req     = rq != 0;
  endtask

  task automatic add(int v, int cls, int rd, int r1, int r2, int r3, int u, int dn, int rq,
                     int er, int ew, int ewr, int ea, int eg, int eb);
    vec_t t;
    t.v = v != 0; t.cls = 2'(cls); t.rd = 6'(rd); t.rs1 = 6'(r1); t.rs2 = 6'(r2);
    t.rs3 = 6'(r3); t.used = 3'(u); t.done = dn != 0; t.req = rq != 0;
    t.e.ready = er != 0; t.e.wbv = ew != 0; t.e.wbrd = 6'(ewr);
    t.e.ack = ea != 0; t.e.gnt = eg != 0; t.e.busy = eb != 0;
    tbl.push_back(t);
  endtask

  // Reference model: every in-flight pipelined op is a record carrying its absolute writeback cycle.
  bit         m_v[2][8];
  int         m_due[2][8];
  logic [5:0] m_rd[2][8];
  bit         m_pend[2];
  logic [5:0] m_drd[2];
  int         now;

  function automatic int lat_m(int n, logic [1:0] c);
    if (c == 2'd0) return n == 0 ? 1 : 0;
    return n == 0 ? 2 : 3;
  endfunction

  function automatic logic [5:0] nrm(int n, logic [5:0] x);
    return n == 1 ? (x & 6'h1f) : x;
  endfunction

  function automatic int due_at(int n, int t);
    for (int j = 0; j < 8; j++) if (m_v[n][j] && m_due[n][j] == t) return j;
    return -1;
  endfunction

  function automatic bit inflight(int n, logic [5:0] x);
    if (x == 6'd0) return 1'b0;
    if (m_pend[n] && m_drd[n] == x) return 1'b1;
    for (int j = 0; j < 8; j++) if (m_v[n][j] && m_rd[n][j] == x) return 1'b1;
    return 1'b0;
  endfunction

  function automatic obs_t model_eval(int n);
    obs_t e;
    int   j0, l;
    bit   hz, st, f0, busy;
    busy = m_pend[n];
    for (int j = 0; j < 8; j++) busy |= m_v[n][j];
    j0 = due_at(n, now);
    l  = lat_m(n, issue_class);
    e.ack = div_done && m_pend[n] && j0 < 0;
    hz = inflight(n, nrm(n, issue_rd)) || (rs_used[0] && inflight(n, nrm(n, rs1)))
      || (rs_used[1] && inflight(n, nrm(n, rs2))) || (rs_used[2] && inflight(n, nrm(n, rs3)));
    if (issue_class == 2'd2) st = m_pend[n] && !e.ack;
    else st = l == 0 ? (j0 >= 0 || div_done) : due_at(n, now + l) >= 0;
    e.ready = !(hz || st);
    f0 = issue_valid && e.ready && issue_class != 2'd2 && l == 0;
    e.wbv  = j0 >= 0 || e.ack || f0;
    e.wbrd = j0 >= 0 ? m_rd[n][j0] : e.ack ? m_drd[n] : f0 ? nrm(n, issue_rd) : 6'd0;
    e.gnt  = ext_req && !e.wbv;
    e.busy = busy;
    return e;
  endfunction

  task automatic model_step(int n, obs_t e);
    bit fire;
    int l;
    fire = issue_valid && e.ready;
    l = lat_m(n, issue_class);
    for (int j = 0; j < 8; j++) if (m_v[n][j] && m_due[n][j] == now) m_v[n][j] = 1'b0;
    if (fire && issue_class == 2'd2) begin
      m_pend[n] = 1'b1;
      m_drd[n]  = nrm(n, issue_rd);
    end else begin
      if (e.ack) m_pend[n] = 1'b0;
      if (fire && l > 0) begin
        for (int j = 0; j < 8; j++) begin
          if (!m_v[n][j]) begin
            m_v[n][j] = 1'b1; m_due[n][j] = now + l; m_rd[n][j] = nrm(n, issue_rd);
            break;
          end
        end
      end
    end
  endtask

  initial begin
    obs_t e;
    logic [5:0] pool[8];
    pool = '{6'h00, 6'h20, 6'h01, 6'h21, 6'h02, 6'h22, 6'h03, 6'h23};

    // ADDMUL then drain
    add(1,0,'h21,0,0,0,0,0,0,   1,0,0,0,0,0);
    add(0,0,0,0,0,0,0,0,0,      1,1,'h21,0,0,1);
    add(0,0,0,0,0,0,0,0,0,      1,0,0,0,0,0);
    // OTHERS then colliding ADDMUL
    add(1,1,'h22,0,0,0,0,0,0,   1,0,0,0,0,0);
    add(1,0,'h23,0,0,0,0,0,0,   0,0,0,0,0,1);
    add(1,0,'h23,0,0,0,0,0,0,   1,1,'h22,0,0,1);
    add(0,0,0,0,0,0,0,0,0,      1,1,'h23,0,0,1);
    add(0,0,0,0,0,0,0,0,0,      1,0,0,0,0,0);
    // RAW on rs2, then x0 never matching
    add(1,0,'h24,0,0,0,0,0,0,   1,0,0,0,0,0);
    add(1,0,'h26,0,'h24,0,2,0,0, 0,1,'h24,0,0,1);
    add(1,0,'h26,0,'h24,0,2,0,0, 1,0,0,0,0,0);
    add(1,0,'h00,0,0,0,0,0,0,   1,1,'h26,0,0,1);
    add(1,0,'h27,0,0,0,1,0,0,   1,1,'h00,0,0,1);
    add(0,0,0,0,0,0,0,0,0,      1,1,'h27,0,0,1);
    add(0,0,0,0,0,0,0,0,0,      1,0,0,0,0,0);
    // DIVSQRT: busy stall, deferred ack, back-to-back divide on the ack cycle
    add(1,2,'h25,0,0,0,0,0,0,   1,0,0,0,0,0);
    add(1,2,'h28,0,0,0,0,0,0,   0,0,0,0,0,1);
    add(1,0,'h29,0,0,0,0,0,0,   1,0,0,0,0,1);
    add(0,0,0,0,0,0,0,1,0,      1,1,'h29,0,0,1);
    add(1,2,'h2A,0,0,0,0,1,0,   1,1,'h25,1,0,1);
    add(0,0,0,0,0,0,0,1,0,      1,1,'h2A,1,0,1);
    add(0,0,0,0,0,0,0,0,0,      1,0,0,0,0,0);
    // External writer loses only on the FPU writeback cycle
    add(1,0,'h2B,0,0,0,0,0,1,   1,0,0,0,1,0);
    add(0,0,0,0,0,0,0,0,1,      1,1,'h2B,0,0,1);
    add(0,0,0,0,0,0,0,0,1,      1,0,0,0,1,0);

    drive(0,0,0,0,0,0,0,0,0);
    #12;
    e = '{ready: 1'b1, wbv: 1'b0, ack: 1'b0, gnt: 1'b0, busy: 1'b0, wbrd: 6'd0};
    cmp_obs("reset_a", act(0), e);
    cmp_obs("reset_b", act(1), e);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      drive(int'(tbl[i].v), int'(tbl[i].cls), int'(tbl[i].rd), int'(tbl[i].rs1),
            int'(tbl[i].rs2), int'(tbl[i].rs3), int'(tbl[i].used), int'(tbl[i].done),
            int'(tbl[i].req));
      @(negedge clk);
      cmp_obs($sformatf("vec%0d", i), act(0), tbl[i].e);
    end

    // Reset with two pipelined slots and a divide in flight
    @(posedge clk); #1 drive(1,2,'h32,0,0,0,0,0,0);
    @(negedge clk) chk("mid.div_issue", 32'(a_ready), 32'd1);
    @(posedge clk); #1 drive(1,1,'h30,0,0,0,0,0,0);
    @(negedge clk) chk("mid.oth1_issue", 32'(a_ready), 32'd1);
    @(posedge clk); #1 drive(1,1,'h33,0,0,0,0,0,0);
    @(negedge clk) chk("mid.oth2_issue", 32'(a_ready), 32'd1);
    @(posedge clk); #1 drive(0,0,0,0,0,0,0,0,0);
    @(negedge clk);
    chk("mid.busy", 32'(a_busy), 32'd1);
    chk("mid.wb_valid", 32'(a_wbv), 32'd1);
    chk("mid.wb_rd", 32'(a_wbrd), 32'h30);
    #1 rst_n = 1'b0;
    #1;
    chk("rst.busy", 32'(a_busy), 32'd0);
    chk("rst.wb_valid", 32'(a_wbv), 32'd0);
    chk("rst.wb_rd", 32'(a_wbrd), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel.ready", 32'(a_ready), 32'd1);
    chk("rel.busy", 32'(a_busy), 32'd0);

    for (int n = 0; n < 2; n++) begin
      m_pend[n] = 1'b0;
      m_drd[n]  = 6'd0;
      for (int j = 0; j < 8; j++) m_v[n][j] = 1'b0;
    end
    now = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      drive(int'($urandom_range(0, 9) < 7), int'($urandom_range(0, 3)),
            int'(pool[$urandom_range(0, 7)]), int'(pool[$urandom_range(0, 7)]),
            int'(pool[$urandom_range(0, 7)]), int'(pool[$urandom_range(0, 7)]),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 2) == 0),
            int'($urandom_range(0, 1)));
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        e = model_eval(n);
        cmp_obs($sformatf("rnd%0d_%s", c, n == 0 ? "a" : "b"), act(n), e);
        model_step(n, e);
      end
      now++;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
